// File: rtl/data_sram_responder.sv
// Data-side memory responder: accepts one load/store at a time on a req/addr_ok handshake
// and answers with a registered data_ok pulse a programmable number of cycles later.
module data_sram_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        wr_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        addr_ok_o,
    output logic        data_ok_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        reqWr_q, reqWr_d;
    logic [1:0]  reqSize_q, reqSize_d;
    logic [31:0] reqAddr_q, reqAddr_d;
    logic [31:0] reqWdata_q, reqWdata_d;
    logic        dataOk_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        commit;

    logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

    // With LATENCY == 1 the commit edge is the accept edge, so the live inputs
    // must be used instead of the not-yet-latched copies.
    logic        curWr;
    logic [1:0]  curSize;
    logic [31:0] curAddr;
    logic [31:0] curWdata;
    logic [ADDR_WIDTH-1:0] curIdx;
    logic        curErr;
    logic [3:0]  curBe;
    logic [31:0] curLanes;
    logic        unusedAddrBits;

    assign curWr    = (state_q == IDLE) ? wr_i    : reqWr_q;
    assign curSize  = (state_q == IDLE) ? size_i  : reqSize_q;
    assign curAddr  = (state_q == IDLE) ? addr_i  : reqAddr_q;
    assign curWdata = (state_q == IDLE) ? wdata_i : reqWdata_q;
    assign curIdx   = curAddr[ADDR_WIDTH+1:2];
    assign unusedAddrBits = ^curAddr[31:ADDR_WIDTH+2];

    always_comb begin
        curErr   = 1'b0;
        curBe    = 4'b0000;
        curLanes = curWdata;
        case (curSize)
            2'b00: begin
                curBe    = 4'b0001 << curAddr[1:0];
                curLanes = {4{curWdata[7:0]}};
            end
            2'b01: begin
                curBe    = 4'b0011 << {curAddr[1], 1'b0};
                curLanes = {2{curWdata[15:0]}};
                curErr   = curAddr[0];
            end
            2'b10: begin
                curBe  = 4'b1111;
                curErr = (curAddr[1:0] != 2'b00);
            end
            default: curErr = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        reqWr_d    = reqWr_q;
        reqSize_d  = reqSize_q;
        reqAddr_d  = reqAddr_q;
        reqWdata_d = reqWdata_q;
        commit     = 1'b0;
        addr_ok_o  = 1'b0;
        case (state_q)
            IDLE: begin
                addr_ok_o = 1'b1;
                if (req_i) begin
                    reqWr_d    = wr_i;
                    reqSize_d  = size_i;
                    reqAddr_d  = addr_i;
                    reqWdata_d = wdata_i;
                    cnt_d      = 4'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            reqWr_q    <= 1'b0;
            reqSize_q  <= 2'b00;
            reqAddr_q  <= 32'd0;
            reqWdata_q <= 32'd0;
            dataOk_q   <= 1'b0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            reqWr_q    <= reqWr_d;
            reqSize_q  <= reqSize_d;
            reqAddr_q  <= reqAddr_d;
            reqWdata_q <= reqWdata_d;
            dataOk_q   <= commit;
            if (commit) begin
                err_q   <= curErr;
                rdata_q <= (curWr || curErr) ? 32'd0 : mem[curIdx];
            end
        end
    end

    // The array has no reset: a store only lands on a completed commit edge.
    always_ff @(posedge clk) begin
        if (commit && curWr && !curErr) begin
            for (int i = 0; i < 4; i++) begin
                if (curBe[i]) begin
                    mem[curIdx][8*i +: 8] <= curLanes[8*i +: 8];
                end
            end
        end
    end

    assign data_ok_o = dataOk_q;
    assign rdata_o   = rdata_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: three instances (LATENCY 2, 1, 3) share clock and reset.
module tb_data_sram_responder;

    logic        clk;
    logic        rst_n;
    logic        req    [3];
    logic        wr     [3];
    logic [1:0]  size   [3];
    logic [31:0] addr   [3];
    logic [31:0] wdata  [3];
    logic        addrOk [3];
    logic        dataOk [3];
    logic [31:0] rdata  [3];
    logic        err    [3];

    int nCompared;
    int nMismatched;

    data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_i(req[0]), .wr_i(wr[0]), .size_i(size[0]),
        .addr_i(addr[0]), .wdata_i(wdata[0]), .addr_ok_o(addrOk[0]),
        .data_ok_o(dataOk[0]), .rdata_o(rdata[0]), .err_o(err[0]));

    data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_i(req[1]), .wr_i(wr[1]), .size_i(size[1]),
        .addr_i(addr[1]), .wdata_i(wdata[1]), .addr_ok_o(addrOk[1]),
        .data_ok_o(dataOk[1]), .rdata_o(rdata[1]), .err_o(err[1]));

    data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_i(req[2]), .wr_i(wr[2]), .size_i(size[2]),
        .addr_i(addr[2]), .wdata_i(wdata[2]), .addr_ok_o(addrOk[2]),
        .data_ok_o(dataOk[2]), .rdata_o(rdata[2]), .err_o(err[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one transaction on instance d and reports the accept-to-data_ok distance (99 = timeout).
    task automatic doTxn(input int d, input logic w, input logic [1:0] s, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic e,
                         output int lat);
        int waitCnt;
        waitCnt = 0;
        @(negedge clk);
        req[d] = 1'b1; wr[d] = w; size[d] = s; addr[d] = a; wdata[d] = wd;
        while (!addrOk[d] && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        @(posedge clk);
        #1 req[d] = 1'b0;
        lat = 99; rd = 32'hxxxxxxxx; e = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (dataOk[d]) begin
                lat = k; rd = rdata[d]; e = err[d];
                break;
            end
        end
    endtask

    task automatic test_reset();
        #3;
        nCompared++;
        if (addrOk[0] !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_addr_ok got %b want 1", addrOk[0]); end
        nCompared++;
        if (dataOk[0] !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_data_ok got %b want 0", dataOk[0]); end
        nCompared++;
        if (rdata[0] !== 32'd0) begin nMismatched++; $display("[TB] FAIL reset_rdata got %h want 0", rdata[0]); end
        nCompared++;
        if (err[0] !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_err got %b want 0", err[0]); end
        #9 rst_n = 1'b1;
    endtask

    task automatic test_latency1();
        logic [31:0] rd; logic e; int lat;
        doTxn(1, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, rd, e, lat);
        nCompared++;
        if (lat !== 1) begin nMismatched++; $display("[TB] FAIL t1_store_lat got %0d want 1", lat); end
        nCompared++;
        if (rd !== 32'd0 || e !== 1'b0) begin nMismatched++; $display("[TB] FAIL t1_store_resp got %h/%b want 0/0", rd, e); end
        doTxn(1, 1'b0, 2'b10, 32'h10, 32'h0, rd, e, lat);
        nCompared++;
        if (lat !== 1) begin nMismatched++; $display("[TB] FAIL t1_load_lat got %0d want 1", lat); end
        nCompared++;
        if (rd !== 32'hDEADBEEF) begin nMismatched++; $display("[TB] FAIL t1_load_data got %h want deadbeef", rd); end
        nCompared++;
        if (e !== 1'b0) begin nMismatched++; $display("[TB] FAIL t1_load_err got %b want 0", e); end
    endtask

    task automatic test_byte_half();
        logic [31:0] rd; logic e; int lat;
        logic [7:0] bytesIn [4];
        bytesIn[0] = 8'h11; bytesIn[1] = 8'h22; bytesIn[2] = 8'h33; bytesIn[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            doTxn(0, 1'b1, 2'b00, 32'h20 + 32'(i), {24'h0, bytesIn[i]}, rd, e, lat);
            nCompared++;
            if (lat !== 2) begin nMismatched++; $display("[TB] FAIL t2_byte_lat got %0d want 2", lat); end
        end
        doTxn(0, 1'b0, 2'b10, 32'h20, 32'h0, rd, e, lat);
        nCompared++;
        if (rd !== 32'h44332211) begin nMismatched++; $display("[TB] FAIL t2_bytes_word got %h want 44332211", rd); end
        doTxn(0, 1'b1, 2'b01, 32'h22, 32'h0000ABCD, rd, e, lat);
        nCompared++;
        if (rd !== 32'd0 || e !== 1'b0) begin nMismatched++; $display("[TB] FAIL t2_half_resp got %h/%b want 0/0", rd, e); end
        doTxn(0, 1'b0, 2'b10, 32'h20, 32'h0, rd, e, lat);
        nCompared++;
        if (rd !== 32'hABCD2211) begin nMismatched++; $display("[TB] FAIL t2_half_word got %h want abcd2211", rd); end
        doTxn(0, 1'b0, 2'b00, 32'h21, 32'h0, rd, e, lat);
        nCompared++;
        if (rd !== 32'hABCD2211) begin nMismatched++; $display("[TB] FAIL t2_byte_load_unshifted got %h want abcd2211", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic e; int lat;
        doTxn(0, 1'b0, 2'b10, 32'h21, 32'h0, rd, e, lat);
        nCompared++;
        if (e !== 1'b1 || rd !== 32'd0 || lat !== 2) begin nMismatched++; $display("[TB] FAIL t3_word_misaligned got err=%b rd=%h lat=%0d want 1/0/2", e, rd, lat); end
        doTxn(0, 1'b1, 2'b01, 32'h23, 32'h0000FFFF, rd, e, lat);
        nCompared++;
        if (e !== 1'b1 || rd !== 32'd0 || lat !== 2) begin nMismatched++; $display("[TB] FAIL t3_half_misaligned got err=%b rd=%h lat=%0d want 1/0/2", e, rd, lat); end
        doTxn(0, 1'b1, 2'b11, 32'h20, 32'hFFFFFFFF, rd, e, lat);
        nCompared++;
        if (e !== 1'b1 || rd !== 32'd0 || lat !== 2) begin nMismatched++; $display("[TB] FAIL t3_size_illegal got err=%b rd=%h lat=%0d want 1/0/2", e, rd, lat); end
        doTxn(0, 1'b0, 2'b10, 32'h20, 32'h0, rd, e, lat);
        nCompared++;
        if (rd !== 32'hABCD2211 || e !== 1'b0) begin nMismatched++; $display("[TB] FAIL t3_mem_unchanged got %h/%b want abcd2211/0", rd, e); end
    endtask

    task automatic test_back_to_back();
        @(posedge clk);
        #1;
        req[2] = 1'b1; wr[2] = 1'b1; size[2] = 2'b10; addr[2] = 32'h40; wdata[2] = 32'hCAFEF00D;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            nCompared++;
            if (addrOk[2] !== ((c % 4) == 0)) begin nMismatched++; $display("[TB] FAIL t4_addr_ok cycle %0d got %b want %b", c, addrOk[2], (c % 4) == 0); end
            nCompared++;
            if (dataOk[2] !== ((c % 4) == 3)) begin nMismatched++; $display("[TB] FAIL t4_data_ok cycle %0d got %b want %b", c, dataOk[2], (c % 4) == 3); end
        end
        req[2] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_txn();
        logic [31:0] rd; logic e; int lat;
        logic sawDataOk;
        doTxn(0, 1'b1, 2'b10, 32'h30, 32'h0, rd, e, lat);
        @(negedge clk);
        req[0] = 1'b1; wr[0] = 1'b1; size[0] = 2'b10; addr[0] = 32'h30; wdata[0] = 32'h5555AAAA;
        @(posedge clk);
        #1 req[0] = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        nCompared++;
        if (addrOk[0] !== 1'b1) begin nMismatched++; $display("[TB] FAIL t5_addr_ok_in_reset got %b want 1", addrOk[0]); end
        #2 rst_n = 1'b1;
        sawDataOk = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (dataOk[0] !== 1'b0) sawDataOk = 1'b1;
        end
        nCompared++;
        if (sawDataOk !== 1'b0) begin nMismatched++; $display("[TB] FAIL t5_no_data_ok got %b want 0", sawDataOk); end
        doTxn(0, 1'b0, 2'b10, 32'h30, 32'h0, rd, e, lat);
        nCompared++;
        if (rd !== 32'h00000000) begin nMismatched++; $display("[TB] FAIL t5_store_discarded got %h want 00000000", rd); end
    endtask

    task automatic test_aliasing();
        logic [31:0] rd; logic e; int lat;
        doTxn(0, 1'b1, 2'b10, 32'h1004, 32'h12345678, rd, e, lat);
        doTxn(0, 1'b0, 2'b10, 32'h0004, 32'h0, rd, e, lat);
        nCompared++;
        if (rd !== 32'h12345678 || e !== 1'b0) begin nMismatched++; $display("[TB] FAIL t6_alias got %h/%b want 12345678/0", rd, e); end
    endtask

    initial begin
        nCompared = 0;
        nMismatched = 0;
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            req[d] = 1'b0; wr[d] = 1'b0; size[d] = 2'b00; addr[d] = 32'd0; wdata[d] = 32'd0;
        end
        test_reset();
        test_latency1();
        test_byte_half();
        test_errors();
        test_back_to_back();
        test_reset_mid_txn();
        test_aliasing();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
